// File: rtl/filter_coef_ctrl.sv
// Purpose: shadow/active coefficient controller for the biquad; atomic commit of a0..b2 + Enable on a sample boundary.
// Latency: writes land in shadow at the next edge; a commit swaps on the first Sample_Tick edge after it is accepted.
// Backpressure: no stall; Wr_En/Commit while a commit is pending are dropped and flagged with a one-cycle Wr_Err.
//
// Ports:
//   Clk, Reset           clock, asynchronous active-high reset
//   Sample_Tick          one-cycle pulse marking the filter sample boundary
//   Wr_En/Wr_Addr/Wr_Data shadow write (addr 0..5 = a0,a1,a2,b0,b1,b2; 6,7 ignored)
//   En_Req, Commit       requested Enable (captured at Commit) and commit strobe
//   Busy, Wr_Err         commit pending; rejected write/commit pulse
//   a0..b2, Enable       active coefficient set and filter enable, registered
//   Commit_Cnt           number of completed swaps, wrapping
// Optional: define FILTER_COEF_READBACK_EN to add Rd_Addr/Rd_Data shadow readback
//   (one-cycle registered latency; addr 6 = en_shadow, addr 7 = 0).

module filter_coef_ctrl #(
  parameter int DATA_W = 16,
  parameter int CNT_W  = 8
) (
  input  logic                     Clk,
  input  logic                     Reset,
  input  logic                     Sample_Tick,
  input  logic                     Wr_En,
  input  logic [2:0]               Wr_Addr,
  input  logic signed [DATA_W-1:0] Wr_Data,
  input  logic                     En_Req,
  input  logic                     Commit,
`ifdef FILTER_COEF_READBACK_EN
  input  logic [2:0]               Rd_Addr,
  output logic [DATA_W-1:0]        Rd_Data,
`endif
  output logic                     Busy,
  output logic                     Wr_Err,
  output logic signed [DATA_W-1:0] a0,
  output logic signed [DATA_W-1:0] a1,
  output logic signed [DATA_W-1:0] a2,
  output logic signed [DATA_W-1:0] b0,
  output logic signed [DATA_W-1:0] b1,
  output logic signed [DATA_W-1:0] b2,
  output logic                     Enable,
  output logic [CNT_W-1:0]         Commit_Cnt
);

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    PENDING = 1'b1
  } state_t;

  localparam int NUM_COEF = 6;

  state_t                     state_q, state_d;
  logic signed [DATA_W-1:0]   shadow_q [NUM_COEF];
  logic signed [DATA_W-1:0]   shadow_d [NUM_COEF];
  logic signed [DATA_W-1:0]   active_q [NUM_COEF];
  logic signed [DATA_W-1:0]   active_d [NUM_COEF];
  logic                       en_shadow_q, en_shadow_d;
  logic                       enable_q, enable_d;
  logic                       wr_err_q, wr_err_d;
  logic [CNT_W-1:0]           cnt_q, cnt_d;

  // Next-state / datapath. Writes are only honoured in IDLE; a write and a
  // commit in the same IDLE cycle both act, so the commit sees the new value
  // because the swap reads shadow_q on a later edge.
  always_comb begin
    state_d     = state_q;
    shadow_d    = shadow_q;
    active_d    = active_q;
    en_shadow_d = en_shadow_q;
    enable_d    = enable_q;
    cnt_d       = cnt_q;
    wr_err_d    = 1'b0;

    case (state_q)
      IDLE: begin
        if (Wr_En && (Wr_Addr < 3'd6)) begin
          shadow_d[Wr_Addr] = Wr_Data;
        end
        // A Sample_Tick in the commit cycle is deliberately ignored: the swap
        // must wait for a tick strictly after the commit edge.
        if (Commit) begin
          state_d     = PENDING;
          en_shadow_d = En_Req;
        end
      end
      PENDING: begin
        // Write and commit together still produce a single error pulse.
        if (Wr_En || Commit) begin
          wr_err_d = 1'b1;
        end
        if (Sample_Tick) begin
          active_d = shadow_q;
          enable_d = en_shadow_q;
          cnt_d    = cnt_q + 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q     <= IDLE;
      en_shadow_q <= 1'b0;
      enable_q    <= 1'b0;
      wr_err_q    <= 1'b0;
      cnt_q       <= '0;
      for (int i = 0; i < NUM_COEF; i++) begin
        shadow_q[i] <= '0;
        active_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      en_shadow_q <= en_shadow_d;
      enable_q    <= enable_d;
      wr_err_q    <= wr_err_d;
      cnt_q       <= cnt_d;
      for (int i = 0; i < NUM_COEF; i++) begin
        shadow_q[i] <= shadow_d[i];
        active_q[i] <= active_d[i];
      end
    end
  end

`ifdef FILTER_COEF_READBACK_EN
  logic [DATA_W-1:0] rd_data_q, rd_data_d;

  // Reads sample the registered shadow, so a same-cycle write returns the old value.
  always_comb begin
    rd_data_d = '0;
    if (Rd_Addr < 3'd6) begin
      rd_data_d = shadow_q[Rd_Addr];
    end else if (Rd_Addr == 3'd6) begin
      rd_data_d = {{(DATA_W-1){1'b0}}, en_shadow_q};
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      rd_data_q <= '0;
    end else begin
      rd_data_q <= rd_data_d;
    end
  end

  assign Rd_Data = rd_data_q;
`endif

  assign Busy       = (state_q == PENDING);
  assign Wr_Err     = wr_err_q;
  assign a0         = active_q[0];
  assign a1         = active_q[1];
  assign a2         = active_q[2];
  assign b0         = active_q[3];
  assign b1         = active_q[4];
  assign b2         = active_q[5];
  assign Enable     = enable_q;
  assign Commit_Cnt = cnt_q;

endmodule

// File: tb/tb_filter_coef_ctrl.sv
// Purpose: randomized + directed bench for filter_coef_ctrl against a transaction-level model.
// Latency: one model update per Clk edge; DUT outputs sampled on the falling edge.
// Backpressure: none; the bench drives every cycle and never waits on a DUT event.

module tb_filter_coef_ctrl;

  localparam int DW = 16;
  localparam int CW = 8;

  logic          Clk = 1'b0;
  logic          Reset;
  logic          Sample_Tick;
  logic          Wr_En;
  logic [2:0]    Wr_Addr;
  logic [DW-1:0] Wr_Data;
  logic          En_Req;
  logic          Commit;
  logic          Busy;
  logic          Wr_Err;
  logic [DW-1:0] a0, a1, a2, b0, b1, b2;
  logic          Enable;
  logic [CW-1:0] Commit_Cnt;
  logic [2:0]    Rd_Addr;
  logic [DW-1:0] Rd_Data;

  filter_coef_ctrl #(.DATA_W(DW), .CNT_W(CW)) dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .Sample_Tick (Sample_Tick),
    .Wr_En       (Wr_En),
    .Wr_Addr     (Wr_Addr),
    .Wr_Data     (Wr_Data),
    .En_Req      (En_Req),
    .Commit      (Commit),
`ifdef FILTER_COEF_READBACK_EN
    .Rd_Addr     (Rd_Addr),
    .Rd_Data     (Rd_Data),
`endif
    .Busy        (Busy),
    .Wr_Err      (Wr_Err),
    .a0          (a0),
    .a1          (a1),
    .a2          (a2),
    .b0          (b0),
    .b1          (b1),
    .b2          (b2),
    .Enable      (Enable),
    .Commit_Cnt  (Commit_Cnt)
  );

`ifndef FILTER_COEF_READBACK_EN
  assign Rd_Data = '0;
`endif

  always #5 Clk = ~Clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    else n_pass++;
  endtask

  // Reference model: a staged coefficient set, an active set, and a flag that
  // says a commit is waiting for its sample boundary.
  logic [DW-1:0] m_sh  [6];
  logic [DW-1:0] m_act [6];
  bit            m_en_sh, m_en, m_pend, m_err;
  int            m_cnt;
  logic [DW-1:0] m_rd;

  task automatic model_reset();
    for (int i = 0; i < 6; i++) begin
      m_sh[i]  = '0;
      m_act[i] = '0;
    end
    m_en_sh = 0; m_en = 0; m_pend = 0; m_err = 0; m_cnt = 0; m_rd = '0;
  endtask

  task automatic model_edge(input bit wr, input logic [2:0] addr, input logic [DW-1:0] data,
                            input bit en, input bit com, input bit tick, input logic [2:0] raddr);
    if (raddr < 6)       m_rd = m_sh[raddr];
    else if (raddr == 6) m_rd = {{(DW-1){1'b0}}, m_en_sh};
    else                 m_rd = '0;
    m_err = 0;
    if (m_pend) begin
      m_err = wr || com;
      if (tick) begin
        m_act  = m_sh;
        m_en   = m_en_sh;
        m_cnt  = (m_cnt + 1) % (1 << CW);
        m_pend = 0;
      end
    end else begin
      if (wr && addr < 6) m_sh[addr] = data;
      if (com) begin
        m_pend  = 1;
        m_en_sh = en;
      end
    end
  endtask

  task automatic check_all();
    logic [DW-1:0] got [6];
    got = '{a0, a1, a2, b0, b1, b2};
    for (int i = 0; i < 6; i++) check($sformatf("coef%0d", i), 32'(got[i]), 32'(m_act[i]));
    check("enable", 32'(Enable), 32'(m_en));
    check("busy",   32'(Busy),   32'(m_pend));
    check("wr_err", 32'(Wr_Err), 32'(m_err));
    check("cnt",    32'(Commit_Cnt), 32'(m_cnt));
`ifdef FILTER_COEF_READBACK_EN
    check("rd_data", 32'(Rd_Data), 32'(m_rd));
`endif
  endtask

  // Drive one cycle (called just after a falling edge), update the model at
  // the rising edge, compare on the next falling edge.
  task automatic cycle(input bit wr, input logic [2:0] addr, input logic [DW-1:0] data,
                       input bit en, input bit com, input bit tick);
    Wr_En = wr; Wr_Addr = addr; Wr_Data = data; En_Req = en; Commit = com; Sample_Tick = tick;
    @(posedge Clk);
    model_edge(wr, addr, data, en, com, tick, Rd_Addr);
    @(negedge Clk);
    check_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 3'd0, '0, 0, 0, 0);
  endtask

  // Asynchronous reset raised between edges; outputs must clear before any edge.
  task automatic do_reset();
    Wr_En = 0; Commit = 0; Sample_Tick = 0; En_Req = 0;
    #2 Reset = 1'b1;
    #1 model_reset();
    check_all();
    @(negedge Clk);
    Reset = 1'b0;
  endtask

  int bcount, ecount;

  initial begin
    Reset = 1'b1; Wr_En = 0; Wr_Addr = '0; Wr_Data = '0; En_Req = 0;
    Commit = 0; Sample_Tick = 0; Rd_Addr = '0;
    model_reset();
    #7 check_all();
    @(negedge Clk);
    Reset = 1'b0;

    // Ticks alone never touch the active set.
    for (int i = 0; i < 10; i++) begin
      cycle(0, 3'd0, '0, 0, 0, 1);
      idle(1);
    end

    // Write b0, a0, commit with Enable requested, tick five cycles later.
    cycle(1, 3'd3, 16'h4000, 0, 0, 0);
    cycle(1, 3'd0, 16'h7FFF, 0, 0, 0);
    bcount = 0;
    cycle(0, 3'd0, '0, 1, 1, 0);
    if (Busy) bcount++;
    for (int i = 0; i < 4; i++) begin
      idle(1);
      if (Busy) bcount++;
    end
    check("a0_before_tick", 32'(a0), 32'h0);
    cycle(0, 3'd0, '0, 0, 0, 1);
    check("busy_len", 32'(bcount), 32'd5);
    check("a0_swap", 32'(a0), 32'h7FFF);
    check("b0_swap", 32'(b0), 32'h4000);
    check("en_swap", 32'(Enable), 32'd1);
    check("cnt_one", 32'(Commit_Cnt), 32'd1);

    // Commit and write while pending are both rejected.
    ecount = 0;
    cycle(0, 3'd0, '0, 0, 1, 0);
    cycle(0, 3'd0, '0, 1, 1, 0);
    if (Wr_Err) ecount++;
    cycle(1, 3'd4, 16'h1234, 0, 0, 0);
    if (Wr_Err) ecount++;
    cycle(1, 3'd4, 16'h5555, 0, 0, 1);
    if (Wr_Err) ecount++;
    check("err_pulses", 32'(ecount), 32'd3);
    check("b1_kept", 32'(b1), 32'h0);
    check("cnt_two", 32'(Commit_Cnt), 32'd2);
    check("en_from_first_commit", 32'(Enable), 32'd0);

    // Commit + tick together: no swap until the following tick.
    cycle(1, 3'd2, 16'h0042, 0, 0, 0);
    cycle(0, 3'd0, '0, 1, 1, 1);
    check("no_swap_same_tick", 32'(a2), 32'h0);
    idle(2);
    cycle(0, 3'd0, '0, 0, 0, 1);
    check("swap_next_tick", 32'(a2), 32'h0042);

    // Write + commit in one IDLE cycle: commit carries the write.
    cycle(1, 3'd1, 16'h8000, 1, 1, 0);
    cycle(0, 3'd0, '0, 0, 0, 1);
    check("a1_with_commit", 32'(a1), 32'h8000);
    check("a0_persist", 32'(a0), 32'h7FFF);

    // Reset in the middle of a pending commit.
    cycle(0, 3'd0, '0, 1, 1, 0);
    do_reset();
    check("rst_a0", 32'(a0), 32'h0);
    cycle(0, 3'd0, '0, 0, 0, 1);
    check("rst_no_swap", 32'(Commit_Cnt), 32'd0);

    // 256 swaps wrap the counter back to zero.
    for (int i = 0; i < 256; i++) begin
      cycle(0, 3'd0, '0, 1, 1, 0);
      cycle(0, 3'd0, '0, 0, 0, 1);
    end
    check("cnt_wrap", 32'(Commit_Cnt), 32'd0);

`ifdef FILTER_COEF_READBACK_EN
    Rd_Addr = 3'd2;
    cycle(1, 3'd2, 16'hFFFE, 0, 0, 0);
    check("rd_old", 32'(Rd_Data), 32'h0);
    cycle(0, 3'd0, '0, 0, 0, 0);
    check("rd_new", 32'(Rd_Data), 32'hFFFE);
    Rd_Addr = 3'd6;
    cycle(0, 3'd0, '0, 1, 0, 0);
    check("rd_en", 32'(Rd_Data), 32'd1);
`endif

    // Random traffic, with occasional asynchronous resets.
    for (int i = 0; i < 3000; i++) begin
      Rd_Addr = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 299) == 0) begin
        do_reset();
      end else begin
        cycle($urandom_range(0, 9) < 3, 3'($urandom_range(0, 7)), DW'($urandom),
              1'($urandom), $urandom_range(0, 9) == 0, $urandom_range(0, 6) == 0);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/filter_coef_ctrl.md
Name: filter_coef_ctrl

Overview:
Coefficient and enable controller for the biquad filter datapath. Accepts coefficient writes from the control side (e.g. the parameter/UI logic) into a shadow set, and commits the shadow set atomically to the active outputs on a sample boundary. The filter never sees a torn coefficient set or an Enable change mid-sample. Active outputs wire directly to the filter's a0..b2 and Enable inputs.

Parameters:
DATA_W, 16, coefficient width; matches filter coefficient ports
CNT_W, 8, width of the commit counter

Ports:
Clk  in  1  system clock
Reset  in  1  asynchronous, active-high reset
Sample_Tick  in  1  one-Clk pulse marking the filter sample boundary
Wr_En  in  1  shadow write strobe
Wr_Addr  in  3  0=a0, 1=a1, 2=a2, 3=b0, 4=b1, 5=b2; 6,7 reserved
Wr_Data  in  DATA_W  signed coefficient value
En_Req  in  1  requested filter Enable, sampled at Commit
Commit  in  1  one-Clk pulse requesting swap of shadow to active
Busy  out  1  commit pending, waiting for Sample_Tick
Wr_Err  out  1  one-Clk pulse: write or commit rejected
a0, a1, a2, b0, b1, b2  out  DATA_W each  active coefficients, registered
Enable  out  1  active filter enable, registered
Commit_Cnt  out  CNT_W  number of completed swaps

Behaviour:
- Reset is asynchronous and active-high.
  - Shadow and active coefficients = 0.
  - Enable = 0, so the filter passes x through.
  - Busy = 0, Wr_Err = 0, Commit_Cnt = 0, FSM = IDLE.
- FSM states:
  - IDLE: Commit -> PENDING, and latch En_Req into en_shadow.
  - PENDING: Sample_Tick -> IDLE, performing the swap in that same clock edge.
- Swap actions, all registered on one edge:
  - a0..b2 <= shadow.
  - Enable <= en_shadow.
  - Commit_Cnt <= Commit_Cnt + 1, wrapping from 2^CNT_W-1 to 0.
- Busy = (state == PENDING), registered.
  - Latency: Commit at edge N gives Busy = 1 after edge N.
  - Swap happens at the first Sample_Tick edge strictly after edge N.
- Writes:
  - Accepted only in IDLE.
  - Wr_En with Wr_Addr 0..5 updates that shadow register at the edge.
  - Wr_Addr 6 or 7: write ignored, no error.
- Rejections (each gives a Wr_Err pulse, state unchanged):
  - Wr_En in PENDING: write dropped, shadow unchanged.
  - Commit in PENDING: ignored.
  - Wr_En and Commit together in PENDING: a single Wr_Err pulse.
- Simultaneous events:
  - Wr_En and Commit in the same IDLE cycle: the write lands in shadow first, and the commit includes it.
  - Commit and Sample_Tick in the same IDLE cycle: no swap; the swap waits for the next Sample_Tick.
  - Sample_Tick in IDLE: no effect; active outputs hold.
  - Sample_Tick and Wr_En in the PENDING swap cycle: the write is still rejected (state was PENDING at sampling).
- Shadow persists after a swap, so partial updates followed by Commit reuse the unchanged values.
- Reset mid-PENDING: the pending commit is discarded and all values return to reset values.
- Coefficients are stored and forwarded unmodified: signed two's complement, no saturation.

Optional Feature:
Macro FILTER_COEF_READBACK_EN.
- Defined:
  - Adds ports Rd_Addr (in, 3) and Rd_Data (out, DATA_W).
  - Rd_Data is registered: one-Clk latency, reading the shadow register at Rd_Addr.
  - Addr 6 returns {DATA_W-1 zeros, en_shadow}; addr 7 returns 0.
  - Reset value of Rd_Data = 0.
  - A read of an address written in the same cycle returns the old value.
- Not defined: ports absent; no readback logic.

Test Plan:
- Reset, then no stimulus for 10 Ticks -> all coefficients 0, Enable 0, Busy 0, Commit_Cnt 0.
- Write b0=0x4000, a0=0x7FFF; En_Req=1; Commit; Tick 5 cycles later -> Busy high for 5 cycles; outputs change only on the Tick edge; Enable 1; Commit_Cnt 1.
- Commit in PENDING, then write b1=0x1234 -> two Wr_Err pulses; after Tick, b1 is still the old value; Commit_Cnt +1 only once.
- Commit and Tick in the same cycle -> no swap; swap at the next Tick.
- Wr_En(a1=0x8000) and Commit in the same IDLE cycle -> after Tick, a1 = 0x8000.
- Reset asserted mid-PENDING -> outputs 0 immediately, without waiting for a Clk edge; a later Tick causes no swap.
- 256 commit/Tick pairs -> Commit_Cnt wraps to 0.
- With FILTER_COEF_READBACK_EN: write a2=0xFFFE, Rd_Addr=2 -> Rd_Data=0xFFFE one cycle later; Rd_Addr=6 returns en_shadow.
